// File: rtl/alu_exec_stage.sv
// Execute stage: the ALU result is computed when an operand set is accepted,
// then queued in a 2-entry skid buffer; condition codes load when an entry retires.
module alu_exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SR1,
  input  logic [WIDTH-1:0] SR2,
  input  logic [1:0]       ALUK,
  input  logic             LD_CC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       NZP
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ld_cc;
  } entry_t;

  logic [1:0]       state;
  entry_t           head, tail;
  logic [WIDTH-1:0] alu;
  logic             accept, retire;

  always_comb begin
    alu = '0;
    case (ALUK)
      2'b00:   alu = SR1 + SR2;
      2'b01:   alu = SR1 & SR2;
      2'b10:   alu = ~SR1;
      default: alu = SR1;
    endcase
  end

  // Handshake signals come from registered state only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign result    = out_valid ? head.res : '0;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      NZP   <= 3'b010;
    end else if (flush) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (retire && head.ld_cc) begin
        if (head.res[WIDTH-1])   NZP <= 3'b100;
        else if (head.res == '0) NZP <= 3'b010;
        else                     NZP <= 3'b001;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= '{res: alu, ld_cc: LD_CC};
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            head <= '{res: alu, ld_cc: LD_CC};
          end else if (accept) begin
            tail  <= '{res: alu, ld_cc: LD_CC};
            state <= FULL;
          end else if (retire) begin
            head  <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (retire) begin
            head  <= tail;
            tail  <= '0;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: handshake, buffering, flush, reset and NZP.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, LD_CC, out_valid, out_ready;
  logic [15:0] SR1, SR2, result;
  logic [1:0]  ALUK;
  logic [2:0]  NZP;
  int          checks = 0;
  int          errors = 0;

  alu_exec_stage #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .SR1(SR1), .SR2(SR2), .ALUK(ALUK), .LD_CC(LD_CC),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .NZP(NZP)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cc);
    in_valid = v; ALUK = op; SR1 = a; SR2 = b; LD_CC = cc;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst_in_ready",  {15'b0, in_ready},  16'd1);
    check("rst_result",    result,             16'h0000);
    check("rst_nzp",       {13'b0, NZP},       16'b010);

    // Overflow into the sign bit sets N
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 16'h7FFF, 16'h0001, 1'b1);
    step();
    in_valid = 1'b0;
    check("add_ovf_valid",  {15'b0, out_valid}, 16'd1);
    check("add_ovf_result", result,             16'h8000);
    step();
    check("add_ovf_nzp",    {13'b0, NZP},       16'b100);
    check("add_ovf_empty",  {15'b0, out_valid}, 16'd0);

    // Wrap to zero, then an untagged AND leaves NZP alone
    drive(1'b1, 2'b00, 16'hFFFF, 16'h0001, 1'b1);
    step();
    in_valid = 1'b0;
    check("add_wrap_result", result, 16'h0000);
    step();
    check("add_wrap_nzp", {13'b0, NZP}, 16'b010);
    drive(1'b1, 2'b01, 16'hF0F0, 16'h0FF0, 1'b0);
    step();
    in_valid = 1'b0;
    check("and_result", result, 16'h00F0);
    step();
    check("and_nzp_kept", {13'b0, NZP},       16'b010);
    check("and_empty",    {15'b0, out_valid}, 16'd0);

    // Fill the buffer with downstream stalled
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 16'h0000, 16'h5555, 1'b0);
    step();
    drive(1'b1, 2'b11, 16'h1234, 16'h5555, 1'b0);
    step();
    in_valid = 1'b0;
    check("full_in_ready",  {15'b0, in_ready},  16'd0);
    check("full_out_valid", {15'b0, out_valid}, 16'd1);
    check("full_head",      result,             16'hFFFF);
    step();
    check("full_hold",      result,             16'hFFFF);
    out_ready = 1'b1;
    step();
    check("drain_second",   result,             16'h1234);
    check("drain_in_ready", {15'b0, in_ready},  16'd1);
    step();
    check("drain_empty",    {15'b0, out_valid}, 16'd0);

    // Back-to-back streaming in ONE
    drive(1'b1, 2'b00, 16'd1, 16'd1, 1'b1);
    step();
    check("stream_r0", result, 16'd2);
    drive(1'b1, 2'b00, 16'd2, 16'd2, 1'b1);
    step();
    check("stream_r1",       result,             16'd4);
    check("stream_r1_valid", {15'b0, out_valid}, 16'd1);
    check("stream_r1_ready", {15'b0, in_ready},  16'd1);
    drive(1'b1, 2'b00, 16'd3, 16'd3, 1'b1);
    step();
    check("stream_r2", result, 16'd6);
    in_valid = 1'b0;
    step();
    check("stream_empty", {15'b0, out_valid}, 16'd0);
    check("stream_nzp",   {13'b0, NZP},       16'b001);

    // Flush from FULL with handshakes active
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 16'h0000, 16'h0, 1'b1);
    step();
    step();
    check("flush_pre_full", {15'b0, in_ready}, 16'd0);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {15'b0, out_valid}, 16'd0);
    check("flush_in_ready",  {15'b0, in_ready},  16'd1);
    check("flush_nzp",       {13'b0, NZP},       16'b001);
    check("flush_result",    result,             16'h0000);
    step();
    check("flush_no_ghost",  {15'b0, out_valid}, 16'd0);
    check("flush_nzp_later", {13'b0, NZP},       16'b001);

    // Reset mid-operation from FULL
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 16'h0000, 16'h0, 1'b1);
    step();
    step();
    in_valid = 1'b0;
    reset = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst2_in_ready",  {15'b0, in_ready},  16'd1);
    check("rst2_result",    result,             16'h0000);
    check("rst2_nzp",       {13'b0, NZP},       16'b010);
    drive(1'b1, 2'b11, 16'h0005, 16'h0, 1'b1);
    step();
    in_valid = 1'b0;
    check("post_rst_result", result, 16'h0005);
    step();
    check("post_rst_nzp",   {13'b0, NZP},       16'b001);
    check("post_rst_empty", {15'b0, out_valid}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
